// File: rtl/ifq.sv
// Instruction fetch queue: DEPTH-entry ring FIFO of {pc, instr, page_fault} between fetch and decode.
// Optional same-cycle empty-queue bypass from if_* to dec_* is enabled by defining IFQ_BYPASS_EN.
module ifq #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [31:0]                if_instr,
  input  logic                       if_page_fault,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [PC_W-1:0]            dec_pc,
  output logic [31:0]                dec_instr,
  output logic                       dec_page_fault,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Handshakes (both sides): a transfer happens on a rising clk edge where
  // valid && ready are both high; flush forces both readies/valids low.

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic             pf_mem    [DEPTH];

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_adv;
  logic             bypass_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign level  = wr_ptr_q - rd_ptr_q;

  always_comb begin
    if_ready = !full && !flush;
    push     = if_valid && if_ready;
`ifdef IFQ_BYPASS_EN
    bypass_hit = empty && !flush && if_valid;
`else
    bypass_hit = 1'b0;
`endif
    dec_valid = (!empty || bypass_hit) && !flush;
    pop       = dec_valid && dec_ready;
    // A bypassed entry consumed this cycle never touches storage or pointers.
    wr_en     = push && !(bypass_hit && dec_ready);
    rd_adv    = pop && !bypass_hit;
  end

  always_comb begin
    if (bypass_hit) begin
      dec_pc         = if_pc;
      dec_instr      = if_instr;
      dec_page_fault = if_page_fault;
    end else begin
      dec_pc         = pc_mem[rd_idx];
      dec_instr      = instr_mem[rd_idx];
      dec_page_fault = pf_mem[rd_idx];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally unreset; dec_* contents are don't-care while dec_valid=0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx]    <= if_pc;
      instr_mem[wr_idx] <= if_instr;
      pf_mem[wr_idx]    <= if_page_fault;
    end
  end

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq (DEPTH=4): reset, fill/drain, full+pop, wrap streaming, flush, faults, bypass.
module tb_ifq;

  localparam int DEPTH = 4;
  localparam int PC_W  = 64;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            if_page_fault;
  logic            dec_valid;
  logic            dec_ready;
  logic [PC_W-1:0] dec_pc;
  logic [31:0]     dec_instr;
  logic            dec_page_fault;
  logic [2:0]      level;

  int total;
  int bad;

  ifq #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_page_fault  (if_page_fault),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .dec_page_fault (dec_page_fault),
    .level          (level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    flush         = 1'b0;
    if_valid      = 1'b0;
    if_pc         = '0;
    if_instr      = '0;
    if_page_fault = 1'b0;
    dec_ready     = 1'b0;
  endtask

  task automatic push_one(input logic [PC_W-1:0] pc, input logic [31:0] ins, input logic pf);
    @(negedge clk);
    drive_idle();
    if_valid      = 1'b1;
    if_pc         = pc;
    if_instr      = ins;
    if_page_fault = pf;
  endtask

  task automatic test_reset();
    #1;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
    total++; if (if_ready !== 1'b1)  begin bad++; $display("FAIL reset_if_ready: got %b want 1", if_ready); end
    total++; if (level !== 3'd0)     begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [PC_W-1:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      push_one(64'h1000 + 64'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
      #1;
      total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL fill_if_ready[%0d]: got %b want 1", i, if_ready); end
`ifndef IFQ_BYPASS_EN
      if (i == 0) begin
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL empty_push_dec_valid: got %b want 0", dec_valid); end
      end
`endif
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd4)    begin bad++; $display("FAIL full_level: got %0d want 4", level); end
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL full_if_ready: got %b want 0", if_ready); end
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'h1000 + 64'(i * 4);
      if (i != 0) @(negedge clk);
      dec_ready = 1'b1;
      #1;
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== 32'hA000_0000 + 32'(i)) begin
        bad++; $display("FAIL drain[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h", i, dec_valid, dec_pc, dec_instr, exp_pc);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd0)     begin bad++; $display("FAIL drained_level: got %0d want 0", level); end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL drained_dec_valid: got %b want 0", dec_valid); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) push_one(64'h7000 + 64'(i * 4), 32'(i), 1'b0);
    @(negedge clk);
    drive_idle();
    if_valid = 1'b1; if_pc = 64'h7010; if_instr = 32'h44; dec_ready = 1'b1;
    #1;
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL full_pop_if_ready: got %b want 0", if_ready); end
    total++; if (dec_pc !== 64'h7000) begin bad++; $display("FAIL full_pop_head: got %h want 7000", dec_pc); end
    @(negedge clk);
    #1;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL refill_if_ready: got %b want 1", if_ready); end
    total++; if (level !== 3'd3)    begin bad++; $display("FAIL refill_level: got %0d want 3", level); end
    total++; if (dec_pc !== 64'h7004) begin bad++; $display("FAIL refill_head: got %h want 7004", dec_pc); end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd3 || dec_pc !== 64'h7008) begin
      bad++; $display("FAIL after_refill: got level=%0d pc=%h want level=3 pc=7008", level, dec_pc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      dec_ready = 1'b1;
      #1;
      total++;
      if (dec_pc !== 64'h7008 + 64'(i * 4)) begin bad++; $display("FAIL refill_drain[%0d]: got %h want %h", i, dec_pc, 64'h7008 + 64'(i * 4)); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_wrap();
    logic [PC_W+31:0] exp_q[$];
    logic [PC_W+31:0] e;
    int pops;
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_idle();
      dec_ready = 1'b1;
      if (k < 10) begin
        if_valid = 1'b1;
        if_pc    = 64'h4000 + 64'(k * 4);
        if_instr = $urandom_range(32'hFFFF_FFFF, 0);
      end
      #1;
`ifndef IFQ_BYPASS_EN
      if (k == 0) begin
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL wrap_latency: got %b want 0", dec_valid); end
      end
`endif
      if (if_valid) begin
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL wrap_if_ready[%0d]: got %b want 1", k, if_ready); end
        if (if_ready) exp_q.push_back({if_pc, if_instr});
      end
      if (dec_valid === 1'b1) begin
        pops++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL wrap_extra[%0d]: got pc=%h want none", k, dec_pc);
        end else begin
          e = exp_q.pop_front();
          if ({dec_pc, dec_instr} !== e) begin bad++; $display("FAIL wrap_order[%0d]: got %h want %h", k, {dec_pc, dec_instr}, e); end
        end
      end
    end
    total++; if (pops != 10) begin bad++; $display("FAIL wrap_count: got %0d want 10", pops); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_flush();
    push_one(64'h6000, 32'h1, 1'b0);
    push_one(64'h6004, 32'h2, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd2) begin bad++; $display("FAIL preflush_level: got %0d want 2", level); end
    @(negedge clk);
    flush = 1'b1; if_valid = 1'b1; if_pc = 64'h6008; dec_ready = 1'b1;
    #1;
    total++; if (if_ready !== 1'b0)  begin bad++; $display("FAIL flush_if_ready: got %b want 0", if_ready); end
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL flush_dec_valid: got %b want 0", dec_valid); end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd0)    begin bad++; $display("FAIL postflush_level: got %0d want 0", level); end
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL postflush_if_ready: got %b want 1", if_ready); end
    push_one(64'h2000, 32'h3, 1'b0);
    @(negedge clk);
    drive_idle();
    dec_ready = 1'b1;
    #1;
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h2000 || level !== 3'd1) begin
      bad++; $display("FAIL postflush_head: got v=%b pc=%h level=%0d want v=1 pc=2000 level=1", dec_valid, dec_pc, level);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_fault();
    push_one(64'h5000, 32'h0000_0013, 1'b1);
    push_one(64'h5004, 32'h0000_0073, 1'b0);
    @(negedge clk);
    drive_idle();
    dec_ready = 1'b1;
    #1;
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h5000 || dec_instr !== 32'h13 || dec_page_fault !== 1'b1) begin
      bad++; $display("FAIL fault_head: got v=%b pc=%h ins=%h pf=%b want v=1 pc=5000 ins=13 pf=1", dec_valid, dec_pc, dec_instr, dec_page_fault);
    end
    @(negedge clk);
    #1;
    total++;
    if (dec_pc !== 64'h5004 || dec_instr !== 32'h73 || dec_page_fault !== 1'b0) begin
      bad++; $display("FAIL nofault_head: got pc=%h ins=%h pf=%b want pc=5004 ins=73 pf=0", dec_pc, dec_instr, dec_page_fault);
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL fault_drained: got %b want 0", dec_valid); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) push_one(64'h8000 + 64'(i * 4), 32'(i), 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd3) begin bad++; $display("FAIL premid_level: got %0d want 3", level); end
    rst = 1'b1;
    #1;
    total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL midrst_dec_valid: got %b want 0", dec_valid); end
    total++; if (if_ready !== 1'b1)  begin bad++; $display("FAIL midrst_if_ready: got %b want 1", if_ready); end
    total++; if (level !== 3'd0)     begin bad++; $display("FAIL midrst_level: got %0d want 0", level); end
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef IFQ_BYPASS_EN
  task automatic test_bypass();
    @(negedge clk);
    drive_idle();
    if_valid = 1'b1; if_pc = 64'h3000; if_instr = 32'h55; dec_ready = 1'b1;
    #1;
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h3000 || dec_instr !== 32'h55) begin
      bad++; $display("FAIL bypass_same_cycle: got v=%b pc=%h want v=1 pc=3000", dec_valid, dec_pc);
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL bypass_level: got %0d want 0", level); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive_idle();
    test_reset();
    test_fill_drain();
    test_full_pop();
    test_wrap();
    test_flush();
    test_fault();
    test_mid_reset();
`ifdef IFQ_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
